// File: rtl/pipe_stage_reg.sv
// Purpose : one pipeline stage register carrying ctrl/data with valid/ready handshake, flush and stall counter.
// Latency : 1 cycle from input handshake to out_valid when the stage is empty.
// Backpressure: default build in_ready = !out_valid || out_ready; PIPE_STAGE_SKID_EN build uses a registered in_ready and a skid entry.
//
// Ports:
//   clk, rst            - sole clock, synchronous active-high reset
//   flush               - synchronous clear; drops every held beat and any beat offered that cycle
//   in_valid/in_ready   - upstream handshake, payload in_ctrl[CTRL_W], in_data[DATA_W]
//   out_valid/out_ready - downstream handshake, payload out_ctrl[CTRL_W], out_data[DATA_W]
//   stall_cnt[16]       - saturating count of cycles with out_valid=1 and out_ready=0
// Build option: define PIPE_STAGE_SKID_EN for the two-entry (main + skid) variant.
module pipe_stage_reg #(
    parameter int DATA_W   = 32,
    parameter int CTRL_W   = 8,
    parameter bit CLR_DATA = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic [15:0]       stall_cnt
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } stateT;

    stateT             state;
    stateT             nextState;
    logic              inFire;
    logic              outFire;
    logic              loadMain;
    logic [CTRL_W-1:0] mainCtrl;
    logic [DATA_W-1:0] mainData;
    logic [15:0]       stallCnt;

    assign out_valid = (state != EMPTY);
    assign out_ctrl  = mainCtrl;
    assign out_data  = mainData;
    assign stall_cnt = stallCnt;

    assign outFire = out_valid && out_ready;
    // A beat offered alongside flush never counts as accepted.
    assign inFire  = in_valid && in_ready && !flush;

`ifdef PIPE_STAGE_SKID_EN
    logic              mainFromSkid;
    logic              loadSkid;
    logic              inReadyQ;
    logic [CTRL_W-1:0] skidCtrl;
    logic [DATA_W-1:0] skidData;

    assign in_ready = inReadyQ;

    always_comb begin
        nextState    = state;
        loadMain     = 1'b0;
        mainFromSkid = 1'b0;
        loadSkid     = 1'b0;
        case (state)
            EMPTY: begin
                if (inFire) begin
                    nextState = BUSY;
                    loadMain  = 1'b1;
                end
            end
            BUSY: begin
                if (inFire && !outFire) begin
                    nextState = FULL;
                    loadSkid  = 1'b1;
                end else if (inFire && outFire) begin
                    loadMain  = 1'b1;
                end else if (outFire) begin
                    nextState = EMPTY;
                end
            end
            FULL: begin
                // in_ready is low here, so only the drain path matters.
                if (outFire) begin
                    nextState    = BUSY;
                    mainFromSkid = 1'b1;
                end
            end
            default: nextState = EMPTY;
        endcase
    end

    // in_ready is registered: it reflects the state being entered at this edge.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            inReadyQ <= 1'b1;
        end else begin
            inReadyQ <= (nextState != FULL);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skidCtrl <= '0;
            skidData <= '0;
        end else if (flush) begin
            skidCtrl <= '0;
            if (CLR_DATA) begin
                skidData <= '0;
            end
        end else if (loadSkid) begin
            skidCtrl <= in_ctrl;
            skidData <= in_data;
        end
    end
`else
    // Single entry: a beat may enter in the same cycle the held one leaves.
    assign in_ready = !out_valid || out_ready;

    always_comb begin
        nextState = state;
        loadMain  = 1'b0;
        if (inFire) begin
            nextState = BUSY;
            loadMain  = 1'b1;
        end else if (outFire) begin
            nextState = EMPTY;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            state <= EMPTY;
        end else begin
            state <= nextState;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mainCtrl <= '0;
            mainData <= '0;
        end else if (flush) begin
            mainCtrl <= '0;
            if (CLR_DATA) begin
                mainData <= '0;
            end
        end else if (loadMain) begin
            mainCtrl <= in_ctrl;
            mainData <= in_data;
`ifdef PIPE_STAGE_SKID_EN
        end else if (mainFromSkid) begin
            mainCtrl <= skidCtrl;
            mainData <= skidData;
`endif
        end
    end

    // A flush cycle leaves the counter untouched even if it is also a stall cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (!flush && out_valid && !out_ready && (stallCnt != 16'hFFFF)) begin
            stallCnt <= stallCnt + 16'd1;
        end
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of datapath payload (operands, immediates).
REQ-002 SHALL have parameter CTRL_W, default 8, width of control payload (regwrite, memwrite, ALU op, etc.).
REQ-003 SHALL have parameter CLR_DATA, default 1, 1 = flush/reset zeroes data payload, 0 = data payload retained.
REQ-004 SHALL have one clock and a synchronous, active-high reset; no other clocks or asynchronous inputs.
REQ-005 clk  input  1  sole clock, all state updates on rising edge.
REQ-006 rst  input  1  synchronous active-high reset.
REQ-007 flush  input  1  synchronous pipeline clear (bubble insertion).
REQ-008 in_valid  input  1  upstream beat present.
REQ-009 in_ready  output  1  stage accepts a beat this cycle.
REQ-010 in_ctrl  input  CTRL_W  upstream control payload.
REQ-011 in_data  input  DATA_W  upstream data payload.
REQ-012 out_valid  output  1  downstream beat present.
REQ-013 out_ready  input  1  downstream accepts beat (0 = stall).
REQ-014 out_ctrl  output  CTRL_W  registered control payload.
REQ-015 out_data  output  DATA_W  registered data payload.
REQ-016 stall_cnt  output  16  saturating count of cycles with out_valid=1 and out_ready=0.

Function
REQ-017 Input handshake SHALL occur when in_valid=1 and in_ready=1; output handshake when out_valid=1 and out_ready=1.
REQ-018 Beats SHALL leave in acceptance order; no beat duplicated or dropped except by flush/rst.
REQ-019 Latency SHALL be exactly 1 cycle: beat accepted at edge N appears on out_* after edge N when stage was empty.
REQ-020 out_ctrl/out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 Simultaneous input and output handshake SHALL sustain one beat per cycle with no bubble.
REQ-022 flush=1 SHALL at the next edge discard all held beats, set out_valid=0, out_ctrl=0, out_data=0 (CLR_DATA=1) or unchanged (CLR_DATA=0).
REQ-023 A beat presented with flush=1 SHALL be discarded even if in_ready=1.
REQ-024 flush SHALL NOT modify stall_cnt.
REQ-025 stall_cnt SHALL increment by 1 per stalled cycle and saturate at 16'hFFFF.
REQ-026 Priority SHALL be rst > flush > handshakes.

Reset
REQ-027 rst=1 SHALL at the next edge set out_valid=0, out_ctrl=0, out_data=0 (regardless of CLR_DATA), stall_cnt=0, state EMPTY.
REQ-028 in_ready SHALL be 1 from the first edge after rst asserts, and SHALL remain 1 while rst is held.
REQ-029 Reset asserted mid-stall or with both entries full SHALL drop all beats; no beat emerges afterwards.

Configuration
REQ-030 Macro PIPE_STAGE_SKID_EN SHALL select the skid-buffer build.
REQ-031 With PIPE_STAGE_SKID_EN: two entries (main, skid); states EMPTY, BUSY (main full), FULL (both full); in_ready SHALL be a register output, 1 iff state != FULL.
REQ-032 Skid transitions: EMPTY+in->BUSY; BUSY+in+no out->FULL; BUSY+out+no in->EMPTY; BUSY+in+out->BUSY; FULL+out->BUSY with skid moved to main in the same edge.
REQ-033 Without PIPE_STAGE_SKID_EN: single entry; in_ready = !out_valid || out_ready (combinational from out_ready); no FULL state.

Verification
REQ-034 rst 1 cycle with in_valid=1, in_data=32'hDEAD_BEEF -> out_valid=0, out_data=0, stall_cnt=0, in_ready=1 next cycle.
REQ-035 Stream beats 1..8 with out_ready=1 every cycle -> out_data 1..8 on 8 consecutive cycles, first one cycle after first acceptance.
REQ-036 Skid build: beats 0xA,0xB with out_ready=0 -> in_ready=0 after 2nd acceptance, stall_cnt counts; out_ready=1 -> 0xA then 0xB, in_ready=1 again.
REQ-037 Hold out_valid=1, out_ready=0 for 70000 cycles -> stall_cnt=16'hFFFF and stays.
REQ-038 flush with FULL state and in_valid=1, in_ctrl=8'hFF -> next cycle out_valid=0, out_ctrl=0, no beat ever emitted; stall_cnt unchanged.
REQ-039 Non-skid build: out_ready toggling 1010 with in_valid=1 constantly -> in_ready equals out_ready each cycle while out_valid=1; order preserved.
